// File: rtl/wall_follower_ctrl.sv
// Wall-following navigation controller: synchronised sensors, left/right-hand rule, timed turns, stuck detection.
// Define WALL_FOLLOWER_DEBOUNCE_EN to add a per-sensor debounce filter; otherwise filtered = synchronised.
module wall_follower_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TURN_CYCLES     = 8,
  parameter int STUCK_LIMIT     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       hand_sel,
  input  logic       front_sensor,
  input  logic       left_sensor,
  input  logic       right_sensor,
  output logic       front,
  output logic       turn_left,
  output logic       turn_right,
  output logic       stuck,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FORWARD     = 3'd1,
    FOLLOW      = 3'd2,
    TURN_AWAY   = 3'd3,
    TURN_TOWARD = 3'd4,
    STUCK       = 3'd5
  } state_t;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..15");
  end
  if (TURN_CYCLES < 1 || TURN_CYCLES > 255) begin : g_bad_turn
    $error("TURN_CYCLES out of range 1..255");
  end
  if (STUCK_LIMIT < 1 || STUCK_LIMIT > 15) begin : g_bad_stuck
    $error("STUCK_LIMIT out of range 1..15");
  end

  localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);
  localparam logic [3:0] STUCK_LIM = 4'(STUCK_LIMIT);

  // Sensor vectors are ordered {front, left, right}.
  logic [2:0] sync1, sync2, filt;

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {front_sensor, left_sensor, right_sensor};
      sync2 <= sync1;
    end
  end

`ifdef WALL_FOLLOWER_DEBOUNCE_EN
  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_CYCLES);
  logic [3:0] deb_cnt [3];

  // NOTE: the counter array is only three small registers, so it is reset like any other flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] + 4'd1 == DEB_LIM) begin
          filt[i]    <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 4'd1;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  logic front_f, left_f, right_f, side_f;
  assign front_f = filt[2];
  assign left_f  = filt[1];
  assign right_f = filt[0];

  state_t     state, state_nxt;
  logic       hand, hand_nxt;
  logic [7:0] turn_cnt, turn_cnt_nxt;
  logic [3:0] turn_count, turn_count_nxt;
  logic       front_nxt, turn_left_nxt, turn_right_nxt, stuck_nxt;
  logic       in_turn, to_turn;

  assign side_f  = hand ? right_f : left_f;
  assign in_turn = (state == TURN_AWAY) || (state == TURN_TOWARD);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    hand_nxt       = hand;
    turn_cnt_nxt   = (turn_cnt != 8'd0) ? turn_cnt - 8'd1 : 8'd0;
    turn_count_nxt = turn_count;
    front_nxt      = 1'b0;
    turn_left_nxt  = 1'b0;
    turn_right_nxt = 1'b0;
    stuck_nxt      = 1'b0;

    case (state)
      IDLE: begin
        turn_count_nxt = '0;
        if (enable) begin
          state_nxt = FORWARD;
          hand_nxt  = hand_sel;
        end
      end
      FORWARD: begin
        turn_count_nxt = '0;
        if (front_f)     state_nxt = TURN_AWAY;
        else if (side_f) state_nxt = FOLLOW;
      end
      FOLLOW: begin
        turn_count_nxt = '0;
        if (front_f)      state_nxt = TURN_AWAY;
        else if (!side_f) state_nxt = TURN_TOWARD;
      end
      TURN_AWAY, TURN_TOWARD: begin
        if (turn_cnt == 8'd0) begin
          if (turn_count == STUCK_LIM) state_nxt = STUCK;
          else if (front_f)            state_nxt = TURN_AWAY;
          else if (side_f)             state_nxt = FOLLOW;
          else                         state_nxt = FORWARD;
        end
      end
      STUCK:   state_nxt = STUCK;
      default: state_nxt = IDLE;
    endcase

    if (!enable) state_nxt = IDLE;

    // A fresh turn starts on entry from a non-turn state or on a reload when the current turn expires.
    to_turn = (state_nxt == TURN_AWAY) || (state_nxt == TURN_TOWARD);
    if (to_turn && (!in_turn || turn_cnt == 8'd0)) begin
      turn_cnt_nxt   = TURN_LOAD;
      turn_count_nxt = turn_count_nxt + 4'd1;
    end

    case (state_nxt)
      FORWARD, FOLLOW: front_nxt = 1'b1;
      TURN_AWAY: begin
        turn_right_nxt = ~hand_nxt;
        turn_left_nxt  = hand_nxt;
      end
      TURN_TOWARD: begin
        turn_left_nxt  = ~hand_nxt;
        turn_right_nxt = hand_nxt;
      end
      STUCK:   stuck_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hand       <= 1'b0;
      turn_cnt   <= '0;
      turn_count <= '0;
      front      <= 1'b0;
      turn_left  <= 1'b0;
      turn_right <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      state      <= state_nxt;
      hand       <= hand_nxt;
      turn_cnt   <= turn_cnt_nxt;
      turn_count <= turn_count_nxt;
      front      <= front_nxt;
      turn_left  <= turn_left_nxt;
      turn_right <= turn_right_nxt;
      stuck      <= stuck_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Directed self-checking bench for wall_follower_ctrl (DEBOUNCE_CYCLES=4, TURN_CYCLES=8, STUCK_LIMIT=3).
module tb_wall_follower_ctrl;

  localparam int DEB  = 4;
  localparam int TURN = 8;
  localparam int SLIM = 3;
`ifdef WALL_FOLLOWER_DEBOUNCE_EN
  localparam int LAT = DEB + 3;  // edges from raw change to state change: 2 sync + DEB filter + 1 FSM
`else
  localparam int LAT = 3;
`endif

  localparam int S_IDLE = 0, S_FWD = 1, S_FOLLOW = 2, S_AWAY = 3, S_TOWARD = 4, S_STUCK = 5;
  // outs = {front, turn_left, turn_right, stuck}
  localparam int O_NONE = 0, O_FWD = 8, O_LEFT = 4, O_RIGHT = 2, O_STUCK = 1;

  logic       clk = 1'b0;
  logic       rst_n, enable, hand_sel;
  logic       front_sensor, left_sensor, right_sensor;
  logic       front, turn_left, turn_right, stuck;
  logic [2:0] state_dbg;
  logic [3:0] outs;

  int checks   = 0;
  int failures = 0;
  int n;

  assign outs = {front, turn_left, turn_right, stuck};

  always #5 clk = ~clk;

  wall_follower_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TURN_CYCLES    (TURN),
    .STUCK_LIMIT    (SLIM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .hand_sel    (hand_sel),
    .front_sensor(front_sensor),
    .left_sensor (left_sensor),
    .right_sensor(right_sensor),
    .front       (front),
    .turn_left   (turn_left),
    .turn_right  (turn_right),
    .stuck       (stuck),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges until state_dbg equals target, or -1 if the budget runs out.
  task automatic wait_state(input int target, input int budget, output int edges);
    edges = 0;
    do begin
      tick();
      edges++;
    end while (int'(state_dbg) != target && edges < budget);
    if (int'(state_dbg) != target) edges = -1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; hand_sel = 1'b0;
    front_sensor = 1'b0; left_sensor = 1'b0; right_sensor = 1'b0;

    #3;
    check("rst_state", int'(state_dbg), S_IDLE);
    check("rst_outs", int'(outs), O_NONE);
    @(negedge clk) rst_n = 1'b1;

    tick();
    check("fwd_state", int'(state_dbg), S_FWD);
    check("fwd_outs", int'(outs), O_FWD);
    repeat (3) tick();
    check("fwd_hold", int'(outs), O_FWD);

`ifdef WALL_FOLLOWER_DEBOUNCE_EN
    left_sensor = 1'b1;
    repeat (DEB - 1) tick();
    left_sensor = 1'b0;
    repeat (10) tick();
    check("glitch_state", int'(state_dbg), S_FWD);
`endif

    // Left-hand follow, wall opens -> turn toward (left) for TURN cycles.
    left_sensor = 1'b1;
    wait_state(S_FOLLOW, 100, n);
    check("follow_lat", n, LAT);
    check("follow_outs", int'(outs), O_FWD);
    left_sensor = 1'b0;
    wait_state(S_TOWARD, 100, n);
    check("toward_l_lat", n, LAT);
    check("toward_l_outs", int'(outs), O_LEFT);
    wait_state(S_FWD, 100, n);
    check("toward_l_len", n, TURN);
    check("after_toward_l", int'(outs), O_FWD);

    // Right-hand rule, latched on IDLE->FORWARD.
    enable = 1'b0;
    tick();
    check("idle_state", int'(state_dbg), S_IDLE);
    check("idle_outs", int'(outs), O_NONE);
    hand_sel = 1'b1; enable = 1'b1;
    tick();
    check("fwd_r_state", int'(state_dbg), S_FWD);
    right_sensor = 1'b1;
    wait_state(S_FOLLOW, 100, n);
    check("follow_r_lat", n, LAT);
    right_sensor = 1'b0;
    wait_state(S_TOWARD, 100, n);
    check("toward_r_lat", n, LAT);
    check("toward_r_outs", int'(outs), O_RIGHT);
    wait_state(S_FWD, 100, n);
    check("toward_r_len", n, TURN);

    // Back to left-hand; hand_sel toggled outside IDLE must be ignored.
    enable = 1'b0;
    tick();
    hand_sel = 1'b0; enable = 1'b1;
    tick();
    hand_sel = 1'b1;
    left_sensor = 1'b1;
    wait_state(S_FOLLOW, 100, n);
    check("follow_l2_lat", n, LAT);
    front_sensor = 1'b1; left_sensor = 1'b0;
    wait_state(S_AWAY, 100, n);
    check("prio_lat", n, LAT);
    check("prio_outs", int'(outs), O_RIGHT);
    front_sensor = 1'b0;
    wait_state(S_FWD, 100, n);
    check("away_len", n, TURN);
    check("after_away", int'(outs), O_FWD);

    // Wall ahead held: three back-to-back turns, then STUCK.
    front_sensor = 1'b1;
    wait_state(S_AWAY, 100, n);
    check("stuck_first_lat", n, LAT);
    wait_state(S_STUCK, 100, n);
    check("stuck_lat", n, SLIM * TURN);
    check("stuck_outs", int'(outs), O_STUCK);
    repeat (5) tick();
    check("stuck_hold", int'(state_dbg), S_STUCK);
    enable = 1'b0; front_sensor = 1'b0;
    tick();
    check("unstuck_state", int'(state_dbg), S_IDLE);
    check("unstuck_outs", int'(outs), O_NONE);
    repeat (LAT + 2) tick();

    // Async reset in the middle of a turn.
    hand_sel = 1'b0; enable = 1'b1;
    tick();
    check("fwd3_state", int'(state_dbg), S_FWD);
    front_sensor = 1'b1;
    wait_state(S_AWAY, 100, n);
    check("away3_lat", n, LAT);
    front_sensor = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midturn_rst_outs", int'(outs), O_NONE);
    check("midturn_rst_state", int'(state_dbg), S_IDLE);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_state", int'(state_dbg), S_FWD);
    check("post_rst_outs", int'(outs), O_FWD);
    front_sensor = 1'b1;
    wait_state(S_AWAY, 100, n);
    check("post_rst_away_lat", n, LAT);
    check("post_rst_away_outs", int'(outs), O_RIGHT);
    front_sensor = 1'b0;
    wait_state(S_FWD, 100, n);
    check("post_rst_away_len", n, TURN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
